// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract
// step per clock, with start/busy/done handshake and a register-file write port.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            rstControl,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [4:0]      rdIn,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            WE,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] writeBack
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ZERO_W   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_W   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   count_r;
  logic [2:0]      op_r;
  logic [4:0]      rd_r;
  logic            neg_r;
  logic            spec_r;
  logic [XLEN-1:0] spec_val_r;
  logic [XLEN-1:0] opnd_r;
  logic [XLEN-1:0] hi_r;
  logic [XLEN-1:0] lo_r;

  logic            signed_a_s;
  logic            signed_b_s;
  logic            sa_s;
  logic            sb_s;
  logic            neg_s;
  logic [XLEN-1:0] ma_s;
  logic [XLEN-1:0] mb_s;
  logic            b_zero_s;
  logic            ovf_s;
  logic            special_s;
  logic [XLEN-1:0] spec_val_s;

  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     div_sh_s;
  logic [XLEN:0]     div_diff_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   result_s;

  // Operand decode at the start edge: magnitudes, result sign and special cases.
  always_comb begin
    signed_a_s = 1'b0;
    signed_b_s = 1'b0;
    case (op)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        signed_a_s = 1'b1;
        signed_b_s = 1'b1;
      end
      3'd2: begin
        signed_a_s = 1'b1;
        signed_b_s = 1'b0;
      end
      default: begin
        signed_a_s = 1'b0;
        signed_b_s = 1'b0;
      end
    endcase
    sa_s = signed_a_s & A[XLEN-1];
    sb_s = signed_b_s & B[XLEN-1];
    ma_s = sa_s ? (ZERO_W - A) : A;
    mb_s = sb_s ? (ZERO_W - B) : B;
    case (op)
      3'd0, 3'd1, 3'd4: neg_s = sa_s ^ sb_s;
      3'd2, 3'd6:       neg_s = sa_s;
      default:          neg_s = 1'b0;
    endcase
    b_zero_s  = (B == ZERO_W);
    ovf_s     = ((op == 3'd4) || (op == 3'd6)) && (A == MOST_NEG) && (B == ONES_W);
    special_s = op[2] & (b_zero_s | ovf_s);
    // op[1] separates remainder ops (REM/REMU) from quotient ops (DIV/DIVU)
    if (b_zero_s) begin
      spec_val_s = op[1] ? A : ONES_W;
    end else if (ovf_s) begin
      spec_val_s = op[1] ? ZERO_W : A;
    end else begin
      spec_val_s = ZERO_W;
    end
  end

  // Datapath for one iteration and the final sign fix / result select.
  always_comb begin
    mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    div_sh_s   = {hi_r, lo_r[XLEN-1]};
    div_diff_s = div_sh_s - {1'b0, opnd_r};
    prod_s     = neg_r ? ({(2*XLEN){1'b0}} - {hi_r, lo_r}) : {hi_r, lo_r};
    quo_s      = neg_r ? (ZERO_W - lo_r) : lo_r;
    rem_s      = neg_r ? (ZERO_W - hi_r) : hi_r;
    case (op_r)
      3'd0:             result_s = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3: result_s = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:       result_s = quo_s;
      3'd6, 3'd7:       result_s = rem_s;
      default:          result_s = ZERO_W;
    endcase
    if (spec_r) begin
      result_s = spec_val_r;
    end else begin
      result_s = result_s;
    end
  end

  // Control FSM, iteration registers and registered write-port outputs.
  always_ff @(posedge CLK or negedge rstControl) begin
    if (!rstControl) begin
      state_r    <= S_IDLE;
      count_r    <= {CW{1'b0}};
      op_r       <= 3'd0;
      rd_r       <= 5'd0;
      neg_r      <= 1'b0;
      spec_r     <= 1'b0;
      spec_val_r <= ZERO_W;
      opnd_r     <= ZERO_W;
      hi_r       <= ZERO_W;
      lo_r       <= ZERO_W;
      busy       <= 1'b0;
      done       <= 1'b0;
      WE         <= 1'b0;
      rd         <= 5'd0;
      writeBack  <= ZERO_W;
    end else begin
      done <= 1'b0;
      WE   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start && !flush) begin
            op_r       <= op;
            rd_r       <= rdIn;
            neg_r      <= neg_s;
            spec_r     <= special_s;
            spec_val_r <= spec_val_s;
            count_r    <= {CW{1'b0}};
            hi_r       <= ZERO_W;
            // Divide shifts the dividend out of lo; multiply shifts the multiplier out.
            opnd_r     <= op[2] ? mb_s : ma_s;
            lo_r       <= op[2] ? ma_s : mb_s;
            busy       <= 1'b1;
            state_r    <= special_s ? S_FIX : S_CALC;
          end else begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_CALC: begin
          if (flush) begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            if (op_r[2]) begin
              if (!div_diff_s[XLEN]) begin
                hi_r <= div_diff_s[XLEN-1:0];
                lo_r <= {lo_r[XLEN-2:0], 1'b1};
              end else begin
                hi_r <= div_sh_s[XLEN-1:0];
                lo_r <= {lo_r[XLEN-2:0], 1'b0};
              end
            end else begin
              {hi_r, lo_r} <= {mul_sum_s, lo_r[XLEN-1:1]};
            end
            count_r <= count_r + CW'(1);
            if (count_r == CW'(XLEN-1)) begin
              state_r <= S_FIX;
            end else begin
              state_r <= S_CALC;
            end
          end
        end
        S_FIX: begin
          if (flush) begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            writeBack <= result_s;
            rd        <= rd_r;
            done      <= 1'b1;
            WE        <= (rd_r != 5'd0);
            state_r   <= S_DONE;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed RV32M results.
module tb_muldiv_unit;

  logic        CLK = 1'b0;
  logic        rstControl;
  logic        start;
  logic [2:0]  op;
  logic [4:0]  rdIn;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic        busy;
  logic        done;
  logic        WE;
  logic [4:0]  rd;
  logic [31:0] writeBack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int k = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .CLK(CLK), .rstControl(rstControl), .start(start), .op(op), .rdIn(rdIn),
    .A(A), .B(B), .flush(flush), .busy(busy), .done(done), .WE(WE), .rd(rd),
    .writeBack(writeBack)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one request for a single edge, then scramble the inputs.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r);
    @(negedge CLK);
    start = 1'b1; op = o; A = a; B = b; rdIn = r;
    @(posedge CLK); #1;
    k = cyc;
    start = 1'b0; op = ~o; A = ~a; B = ~b; rdIn = ~r;
  endtask

  task automatic wait_done(output int lat);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    lat = cyc - k;
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp,
                     input bit special);
    int lat;
    launch(o, a, b, r);
    wait_done(lat);
    chk({tag, " latency"}, lat, special ? 32'd1 : 32'd33);
    chk({tag, " result"}, writeBack, exp);
    chk({tag, " we"}, {31'd0, WE}, {31'd0, (r != 5'd0)});
    chk({tag, " rd"}, {27'd0, rd}, {27'd0, r});
    @(posedge CLK); #1;
    chk({tag, " done drop"}, {31'd0, done}, 32'd0);
    chk({tag, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int dcount;
    rstControl = 1'b0; start = 1'b0; flush = 1'b0;
    op = 3'd0; rdIn = 5'd0; A = 32'd0; B = 32'd0;
    #12;
    chk("reset ctl", {27'd0, busy, done, WE, 2'b00}, 32'd0);
    chk("reset rd", {27'd0, rd}, 32'd0);
    chk("reset wb", writeBack, 32'd0);
    @(negedge CLK); rstControl = 1'b1;

    run("mul",    3'd0, 32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0);
    run("mulhu",  3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 1'b0);
    run("mulh",   3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd7,  32'h00000000, 1'b0);
    run("mulhsu", 3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 1'b0);
    run("div",    3'd4, 32'hFFFFFFF9,   32'd2,        5'd9,  32'hFFFFFFFD, 1'b0);
    run("rem",    3'd6, 32'hFFFFFFF9,   32'd2,        5'd10, 32'hFFFFFFFF, 1'b0);
    run("divu",   3'd5, 32'd100,        32'd7,        5'd11, 32'd14,       1'b0);
    run("remu",   3'd7, 32'd100,        32'd7,        5'd12, 32'd2,        1'b0);
    run("divu0",  3'd5, 32'd55,         32'd0,        5'd13, 32'hFFFFFFFF, 1'b1);
    run("rem0",   3'd6, 32'h00001234,   32'd0,        5'd14, 32'h00001234, 1'b1);
    run("divovf", 3'd4, 32'h80000000,   32'hFFFFFFFF, 5'd15, 32'h80000000, 1'b1);
    run("removf", 3'd6, 32'h80000000,   32'hFFFFFFFF, 5'd16, 32'h00000000, 1'b1);
    run("rd0",    3'd0, 32'd3,          32'd4,        5'd0,  32'd12,       1'b0);

    // A second start during CALC must be ignored.
    launch(3'd0, 32'd6, 32'd7, 5'd20);
    repeat (5) @(posedge CLK);
    @(negedge CLK); start = 1'b1; op = 3'd5; A = 32'd9; B = 32'd3; rdIn = 5'd21;
    @(posedge CLK); #1; start = 1'b0;
    wait_done(lat);
    chk("restart latency", lat, 32'd33);
    chk("restart result", writeBack, 32'd42);
    chk("restart rd", {27'd0, rd}, 32'd20);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (done) dcount++;
    end
    chk("restart single done", dcount, 32'd0);

    // Flush in CALC: no done, result register holds 42.
    launch(3'd5, 32'd100, 32'd3, 5'd22);
    while (cyc < k + 9) begin @(posedge CLK); #1; end
    @(negedge CLK); flush = 1'b1;
    @(posedge CLK); #1; flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (done || WE) dcount++;
    end
    chk("flush no done", dcount, 32'd0);
    chk("flush wb kept", writeBack, 32'd42);

    // Asynchronous reset mid-CALC clears every output at once.
    launch(3'd0, 32'd5, 32'd5, 5'd3);
    repeat (10) @(posedge CLK);
    @(negedge CLK); rstControl = 1'b0;
    #1;
    chk("areset ctl", {27'd0, busy, done, WE, 2'b00}, 32'd0);
    chk("areset rd", {27'd0, rd}, 32'd0);
    chk("areset wb", writeBack, 32'd0);
    @(negedge CLK); rstControl = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (done) dcount++;
    end
    chk("areset no done", dcount, 32'd0);

    run("post", 3'd7, 32'hFFFFFFF9, 32'd10, 5'd31, 32'd9, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
